// File: rtl/div_ctrl.sv
// div_ctrl: sequences DIV/DIVU/REM/REMU requests through a shared unsigned iterative divider core with sign fix-up and flush draining.
module div_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            core_start_o,
    output logic [XLEN-1:0] core_dividend_o,
    output logic [XLEN-1:0] core_divisor_o,
    input  logic            core_done_i,
    input  logic [XLEN-1:0] core_quot_i,
    input  logic [XLEN-1:0] core_rem_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o,
    output logic            busy_o
);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, FIX, RESP, DRAIN} state_t;

    state_t          state, next;
    logic            is_rem, neg1, neg2;
    logic [4:0]      rd;
    logic [XLEN-1:0] dvd, dvs, quot, rem, res;
    logic            sgn, n1, n2, special, acc;
    logic [XLEN-1:0] m1, m2, spec_res, fix_res;

    always_comb begin
        sgn      = ~op_i[0];
        n1       = sgn & rs1_i[XLEN-1];
        n2       = sgn & rs2_i[XLEN-1];
        m1       = n1 ? -rs1_i : rs1_i;
        m2       = n2 ? -rs2_i : rs2_i;
        special  = (rs2_i == '0) | (sgn & (rs1_i == MIN) & (&rs2_i));
        spec_res = (rs2_i == '0) ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : MIN);
        fix_res  = is_rem ? (neg1 ? -rem : rem) : ((neg1 ^ neg2) ? -quot : quot);
        acc      = req_valid_i & req_ready_o;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = acc ? (special ? RESP : LAUNCH) : IDLE;
            LAUNCH:  next = flush_i ? IDLE : WAIT;
            WAIT:    next = flush_i ? (core_done_i ? IDLE : DRAIN) : (core_done_i ? FIX : WAIT);
            FIX:     next = flush_i ? IDLE : RESP;
            RESP:    next = (flush_i | resp_ready_i) ? IDLE : RESP;
            DRAIN:   next = core_done_i ? IDLE : DRAIN;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            is_rem <= 1'b0;
            neg1   <= 1'b0;
            neg2   <= 1'b0;
            rd     <= '0;
            dvd    <= '0;
            dvs    <= '0;
            quot   <= '0;
            rem    <= '0;
            res    <= '0;
        end else begin
            state <= next;
            if (acc) begin
                is_rem <= op_i[1];
                neg1   <= n1;
                neg2   <= n2;
                rd     <= rd_i;
                dvd    <= m1;
                dvs    <= m2;
                if (special) res <= spec_res;
            end
            if (state == WAIT && core_done_i) begin
                quot <= core_quot_i;
                rem  <= core_rem_i;
            end
            if (state == FIX) res <= fix_res;
        end
    end

    assign req_ready_o     = (state == IDLE) & ~flush_i;
    assign core_start_o    = (state == LAUNCH) & ~flush_i;
    assign resp_valid_o    = state == RESP;
    assign busy_o          = state != IDLE;
    assign core_dividend_o = dvd;
    assign core_divisor_o  = dvs;
    assign result_o        = res;
    assign rd_o            = rd;
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller between the EX stage and the shared iterative magnitude divider core of the RV32M unit. Accepts DIV/DIVU/REM/REMU requests over a valid/ready handshake and resolves divide-by-zero and signed-overflow cases locally, without starting the core. All other requests are converted to unsigned magnitudes, the core is launched, and the controller waits for the core's done pulse. It then applies sign correction and holds the result on a valid/ready response port until writeback accepts it. It also handles pipeline flush, including draining an in-flight core operation that cannot be aborted.

## Interface
- XLEN, 32, operand/result width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  controller can accept a request
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_i  in  XLEN  dividend
- rs2_i  in  XLEN  divisor
- rd_i  in  5  destination tag, returned unchanged
- flush_i  in  1  kill current operation
- core_start_o  out  1  one-cycle launch pulse to core
- core_dividend_o  out  XLEN  unsigned dividend magnitude
- core_divisor_o  out  XLEN  unsigned divisor magnitude
- core_done_i  in  1  core result valid, one-cycle pulse
- core_quot_i  in  XLEN  unsigned quotient
- core_rem_i  in  XLEN  unsigned remainder
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  consumer accepts result
- result_o  out  XLEN  final quotient or remainder
- rd_o  out  5  tag of result
- busy_o  out  1  high in every state except IDLE

## Operation
- **States:** IDLE, LAUNCH, WAIT, FIX, RESP, DRAIN.
- **Accept:** `req_ready_o = (state==IDLE) & ~flush_i`. A request is accepted when `req_valid_i & req_ready_o`. On accept, latch op, rd, the operand sign bits, and the magnitudes.
- **Signedness:** signed ops (DIV/REM) take the two's-complement magnitude of negative operands. Unsigned ops (DIVU/REMU) pass operands through unchanged.
- **Special cases at accept** (go IDLE→RESP; core untouched):
  - rs2==0: quotient 0xFFFF_FFFF; remainder = rs1.
  - Signed op with rs1==0x8000_0000 and rs2==0xFFFF_FFFF: quotient 0x8000_0000; remainder 0.
- **Normal path:** IDLE→LAUNCH→WAIT→FIX→RESP→IDLE.
  - LAUNCH: `core_start_o` is high for exactly one cycle, with magnitudes stable on `core_dividend_o`/`core_divisor_o`. The magnitudes stay stable until `core_done_i`.
  - WAIT: stays in WAIT until `core_done_i`. On that cycle, latch `core_quot_i` and `core_rem_i`.
  - FIX (signed ops only):
    - Quotient is negated when the operand signs differ.
    - Remainder is negated when the dividend was negative.
    - Unsigned ops pass through FIX unchanged.
  - RESP: `resp_valid_o=1`; `result_o`/`rd_o` stay stable until `resp_ready_i`. Go to IDLE on handshake.
- **Flush (`flush_i` has priority over all transitions):**
  - IDLE: no accept this cycle.
  - LAUNCH: `core_start_o` is suppressed; go to IDLE.
  - WAIT: go to DRAIN, unless `core_done_i` is high in the same cycle, in which case go to IDLE.
  - DRAIN: wait for `core_done_i`, discard the results, then go to IDLE. `req_ready_o=0` throughout.
  - FIX or RESP: go to IDLE; `resp_valid_o` is 0 next cycle. A RESP handshake in the same cycle counts as delivered.
- `core_done_i` outside WAIT/DRAIN is ignored.
- **Reset:** rst low at a clock edge forces IDLE and clears all latched data, mid-operation included. The core is not drained after reset; core reset is the system's responsibility.

## Timing
- Reset values: state IDLE, `req_ready_o` 1, `resp_valid_o` 0, `core_start_o` 0, `busy_o` 0, and `result_o`, `rd_o`, `core_dividend_o`, `core_divisor_o` all 0.
- Special case: accept at cycle 0, `resp_valid_o` at cycle 1.
- Normal case, with the core taking L cycles from start to done:
  - Accept at cycle 0.
  - `core_start_o` at cycle 1.
  - `core_done_i` at cycle 1+L.
  - FIX at cycle 2+L.
  - `resp_valid_o` at cycle 3+L.
- Next accept is possible in the cycle after the response handshake. There is no back-to-back overlap.
- `core_start_o`, `resp_valid_o` and `busy_o` are driven from registered state. `req_ready_o` is combinational only through `flush_i`.

## Test plan
Core model: fixed L=8; checks the one-cycle start pulse and stable operands until done.
- DIV rs1=0xFFFF_FFF9 (-7), rs2=2 -> `core_dividend_o`=7, `core_divisor_o`=2, `result_o`=0xFFFF_FFFD at cycle 11. Same operands with REM -> 0xFFFF_FFFF.
- DIVU rs1=0xFFFF_FFFF, rs2=0 -> `result_o`=0xFFFF_FFFF at cycle 1, `core_start_o` never asserted. REMU with the same operands -> 0xFFFF_FFFF.
- REM rs1=0x8000_0000, rs2=0xFFFF_FFFF -> 0 at cycle 1. DIV with the same operands -> 0x8000_0000.
- DIVU 100/7 with `resp_ready_i` held low 5 cycles -> `resp_valid_o` stays high with `result_o`=14, `rd_o` unchanged. Handshake then returns IDLE, and a new request is accepted the next cycle.
- Flush 3 cycles after start -> DRAIN with `req_ready_o`=0, `core_done_i` discarded, `resp_valid_o` never asserted, `req_ready_o`=1 the cycle after done.
- rst low during WAIT -> next cycle all outputs at reset values. A new REMU 9/4 returns 1.
